// File: rtl/blood_sprite_renderer_if.sv
// blood_sprite_renderer_if: scan, control, ROM and overlay signals of the blood-sprite renderer.
// BLOOD_MIRROR_EN adds the mirror input.
interface blood_sprite_renderer_if;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        video_on;
   logic        frame_tick;
   logic        trigger;
   logic [9:0]  pos_x;
   logic [9:0]  pos_y;
`ifdef BLOOD_MIRROR_EN
   logic        mirror;
`endif
   logic [5:0]  rom_row;
   logic [5:0]  rom_col;
   logic [3:0]  rom_frame;
   logic [11:0] rom_data;
   logic [11:0] rgb_out;
   logic        sprite_on;
   logic        busy;
   logic        done;
   modport master (
      output pixel_x, pixel_y, video_on, frame_tick, trigger, pos_x, pos_y,
`ifdef BLOOD_MIRROR_EN
      output mirror,
`endif
      output rom_data,
      input  rom_row, rom_col, rom_frame, rgb_out, sprite_on, busy, done
   );
   modport slave (
      input  pixel_x, pixel_y, video_on, frame_tick, trigger, pos_x, pos_y,
`ifdef BLOOD_MIRROR_EN
      input  mirror,
`endif
      input  rom_data,
      output rom_row, rom_col, rom_frame, rgb_out, sprite_on, busy, done
   );
endinterface

// File: rtl/blood_sprite_renderer.sv
// blood_sprite_renderer: 64x64 animated blood-splatter overlay with a 3-cycle pixel pipeline.
// BLOOD_MIRROR_EN enables horizontal mirroring latched on trigger.
module blood_sprite_renderer #(
   parameter int          NUM_FRAMES  = 10,
   parameter int          FRAME_TICKS = 4,
   parameter logic [11:0] TRANSPARENT = 12'h000
) (
   input logic                    clk,
   input logic                    reset_n,
   blood_sprite_renderer_if.slave bus
);
   localparam int TW = FRAME_TICKS > 1 ? $clog2(FRAME_TICKS) : 1;
   localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2;
   logic [1:0]    state_q, state_d;
   logic [3:0]    frame_q, frame_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [9:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic          mirror_q, mirror_d;
   logic [10:0]   dx, dy;
   logic [5:0]    col;
   logic          hit, accept, step, last;
   logic [5:0]    row_q, col_q;
   logic          hit1_q, hit2_q, on_q;
   logic [11:0]   rgb_q;
   always_comb begin
      accept   = bus.trigger & (state_q != DONE);
      step     = (state_q == PLAY) & bus.frame_tick & (tick_q == TW'(FRAME_TICKS - 1));
      last     = frame_q == 4'(NUM_FRAMES - 1);
      state_d  = state_q == DONE ? IDLE : accept ? PLAY : (step & last) ? DONE : state_q;
      frame_d  = accept ? 4'd0 : (step & ~last) ? frame_q + 4'd1 : frame_q;
      tick_d   = (accept | step) ? '0 : ((state_q == PLAY) & bus.frame_tick) ? tick_q + 1'b1 : tick_q;
      pos_x_d  = accept ? bus.pos_x : pos_x_q;
      pos_y_d  = accept ? bus.pos_y : pos_y_q;
`ifdef BLOOD_MIRROR_EN
      mirror_d = accept ? bus.mirror : mirror_q;
`else
      mirror_d = 1'b0;
`endif
      // 11-bit differences keep positions near the right/bottom edge from wrapping into a hit
      dx  = {1'b0, bus.pixel_x} - {1'b0, pos_x_q};
      dy  = {1'b0, bus.pixel_y} - {1'b0, pos_y_q};
      hit = (bus.pixel_x >= pos_x_q) & (dx < 11'd64) & (bus.pixel_y >= pos_y_q) & (dy < 11'd64)
            & bus.video_on & (state_q == PLAY);
      col = mirror_q ? 6'd63 - dx[5:0] : dx[5:0];
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         frame_q  <= '0;
         tick_q   <= '0;
         pos_x_q  <= '0;
         pos_y_q  <= '0;
         mirror_q <= 1'b0;
         row_q    <= '0;
         col_q    <= '0;
         hit1_q   <= 1'b0;
         hit2_q   <= 1'b0;
         on_q     <= 1'b0;
         rgb_q    <= '0;
      end else begin
         state_q  <= state_d;
         frame_q  <= frame_d;
         tick_q   <= tick_d;
         pos_x_q  <= pos_x_d;
         pos_y_q  <= pos_y_d;
         mirror_q <= mirror_d;
         row_q    <= hit ? dy[5:0] : 6'd0;
         col_q    <= hit ? col : 6'd0;
         hit1_q   <= hit;
         hit2_q   <= hit1_q;
         on_q     <= hit2_q & (bus.rom_data != TRANSPARENT);
         rgb_q    <= (hit2_q & (bus.rom_data != TRANSPARENT)) ? bus.rom_data : 12'h000;
      end
   end
   assign bus.rom_row   = row_q;
   assign bus.rom_col   = col_q;
   assign bus.rom_frame = frame_q;
   assign bus.rgb_out   = rgb_q;
   assign bus.sprite_on = on_q;
   assign bus.busy      = state_q == PLAY;
   assign bus.done      = state_q == DONE;
endmodule

// File: tb/tb_blood_sprite_renderer.sv
// tb_blood_sprite_renderer: directed plus randomized checks against a tick-count animation model.
// Build with BLOOD_MIRROR_EN to also exercise mirroring.
module tb_blood_sprite_renderer;
   localparam int NF = 10, FT = 4;
   logic clk = 1'b0, reset_n = 1'b0;
   always #5 clk = ~clk;
   blood_sprite_renderer_if bus();
   blood_sprite_renderer #(.NUM_FRAMES(NF), .FRAME_TICKS(FT), .TRANSPARENT(12'h000))
      dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   int vectors = 0, errs = 0;
   // Test ROM: origin pixel is red, every fifth anti-diagonal is transparent
   function automatic logic [11:0] rom(input logic [3:0] f, input logic [5:0] r, input logic [5:0] c);
      if (r == 6'd0 && c == 6'd0) return 12'hE00;
      if ((int'(r) + int'(c)) % 5 == 0) return 12'h000;
      return {f, r[3:0], c[3:0]};
   endfunction
   always_ff @(posedge clk) bus.rom_data <= rom(bus.rom_frame, bus.rom_row, bus.rom_col);
   logic        m_busy, m_done, m_mir;
   int          m_ticks, m_px, m_py;
   logic        s1_hit, s2_hit, s3_on;
   logic [5:0]  s1_row, s1_col;
   logic [11:0] s2_data, s3_rgb;
   function automatic int m_frame();
      return m_ticks >= NF * FT ? NF - 1 : m_ticks / FT;
   endfunction
   task automatic chk(input string n, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", n, got, exp, $time);
      end
   endtask
   task automatic model_step();
      int dxi, dyi;
      logic h;
      if (!reset_n) begin
         m_busy = 0; m_done = 0; m_mir = 0; m_ticks = 0; m_px = 0; m_py = 0;
         s1_hit = 0; s1_row = 0; s1_col = 0; s2_hit = 0; s2_data = 0; s3_on = 0; s3_rgb = 0;
      end else begin
         s3_on   = s2_hit && s2_data != 12'h000;
         s3_rgb  = s3_on ? s2_data : 12'h000;
         s2_hit  = s1_hit;
         s2_data = rom(4'(m_frame()), s1_row, s1_col);
         dxi = int'(bus.pixel_x) - m_px;
         dyi = int'(bus.pixel_y) - m_py;
         h = dxi >= 0 && dxi < 64 && dyi >= 0 && dyi < 64 && bus.video_on && m_busy;
         s1_hit = h;
         s1_row = h ? 6'(dyi) : 6'd0;
         s1_col = h ? (m_mir ? 6'(63 - dxi) : 6'(dxi)) : 6'd0;
         if (m_done) m_done = 0;
         else if (bus.trigger) begin
            m_busy = 1; m_ticks = 0; m_px = int'(bus.pos_x); m_py = int'(bus.pos_y);
`ifdef BLOOD_MIRROR_EN
            m_mir = bus.mirror;
`endif
         end else if (m_busy && bus.frame_tick) begin
            m_ticks++;
            if (m_ticks == NF * FT) begin m_busy = 0; m_done = 1; end
         end
      end
   endtask
   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk("rom_row", int'(bus.rom_row), int'(s1_row));
      chk("rom_col", int'(bus.rom_col), int'(s1_col));
      chk("rom_frame", int'(bus.rom_frame), m_frame());
      chk("rgb_out", int'(bus.rgb_out), int'(s3_rgb));
      chk("sprite_on", int'(bus.sprite_on), int'(s3_on));
      chk("busy", int'(bus.busy), int'(m_busy));
      chk("done", int'(bus.done), int'(m_done));
   endtask
   task automatic px(input int x, input int y);
      bus.pixel_x = 10'(x); bus.pixel_y = 10'(y);
   endtask
   task automatic ticks(input int n);
      repeat (n) begin
         bus.frame_tick = 1; step();
         bus.frame_tick = 0; step();
      end
   endtask
   initial begin
      bus.video_on = 1; bus.frame_tick = 0; bus.trigger = 1;
      bus.pos_x = 10'd100; bus.pos_y = 10'd200;
`ifdef BLOOD_MIRROR_EN
      bus.mirror = 0;
`endif
      px(100, 200);
      repeat (3) step();
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_rgb", int'(bus.rgb_out), 0);
      chk("rst_on", int'(bus.sprite_on), 0);
      chk("rst_row", int'(bus.rom_row), 0);
      reset_n = 1; px(0, 0);
      step();
      chk("trig_busy", int'(bus.busy), 1);
      bus.trigger = 0;
      px(100, 200); step();
      chk("corner_row", int'(bus.rom_row), 0);
      chk("corner_col", int'(bus.rom_col), 0);
      px(164, 200); step();
      chk("right_out_row", int'(bus.rom_row), 0);
      px(163, 263); step();
      chk("corner_rgb", int'(bus.rgb_out), 12'hE00);
      chk("corner_on", int'(bus.sprite_on), 1);
      chk("far_row", int'(bus.rom_row), 63);
      chk("far_col", int'(bus.rom_col), 63);
      px(101, 204); step();
      chk("right_out_on", int'(bus.sprite_on), 0);
      bus.video_on = 0; px(100, 200); step();
      bus.video_on = 1; px(0, 0); step();
      chk("transp_on", int'(bus.sprite_on), 0);
      chk("transp_rgb", int'(bus.rgb_out), 0);
      step();
      chk("blank_on", int'(bus.sprite_on), 0);
      bus.trigger = 1; step(); bus.trigger = 0;
      ticks(4);
      chk("frame_after4", int'(bus.rom_frame), 1);
      ticks(32);
      chk("frame_after36", int'(bus.rom_frame), 9);
      ticks(3);
      bus.frame_tick = 1; step(); bus.frame_tick = 0;
      chk("done_pulse", int'(bus.done), 1);
      chk("done_busy", int'(bus.busy), 0);
      step();
      chk("done_clear", int'(bus.done), 0);
      bus.trigger = 1; px(100, 200); step(); bus.trigger = 0;
      ticks(17);
      chk("frame_after17", int'(bus.rom_frame), 4);
      bus.trigger = 1; bus.frame_tick = 1; bus.pos_x = 10'd10; bus.pos_y = 10'd10; step();
      bus.trigger = 0; bus.frame_tick = 0;
      chk("retrig_frame", int'(bus.rom_frame), 0);
      px(10, 10); step(); step(); step();
      chk("retrig_on", int'(bus.sprite_on), 1);
      chk("retrig_rgb", int'(bus.rgb_out), 12'hE00);
      ticks(39);
      chk("retrig_busy39", int'(bus.busy), 1);
      bus.frame_tick = 1; step(); bus.frame_tick = 0;
      chk("retrig_done", int'(bus.done), 1);
      bus.pos_x = 10'd1000; bus.pos_y = 10'd0; bus.trigger = 1; step(); bus.trigger = 0;
      px(5, 5); step();
      chk("nowrap_row", int'(bus.rom_row), 0);
      chk("nowrap_col", int'(bus.rom_col), 0);
`ifdef BLOOD_MIRROR_EN
      bus.pos_x = 10'd100; bus.pos_y = 10'd200; bus.mirror = 1; bus.trigger = 1; step();
      bus.trigger = 0; bus.mirror = 0;
      px(100, 200); step();
      chk("mirror_col63", int'(bus.rom_col), 63);
      px(163, 200); step();
      chk("mirror_col0", int'(bus.rom_col), 0);
`endif
      for (int i = 0; i < 3000; i++) begin
         reset_n = ($urandom % 400) != 0;
         bus.trigger = ($urandom % 50) == 0;
         bus.frame_tick = ($urandom % 6) == 0;
         bus.video_on = ($urandom % 10) != 0;
         bus.pos_x = ($urandom % 4 == 0) ? 10'(960 + $urandom % 64) : 10'($urandom % 1024);
         bus.pos_y = 10'($urandom % 1024);
`ifdef BLOOD_MIRROR_EN
         bus.mirror = $urandom % 2 == 1;
`endif
         if ($urandom % 3 == 0) px(int'($urandom % 1024), int'($urandom % 1024));
         else px(m_px + int'($urandom_range(0, 69)) - 3, m_py + int'($urandom_range(0, 69)) - 3);
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/blood_sprite_renderer.md
# blood_sprite_renderer

Downstream consumer of the per-frame 64x64 blood-splatter sprite ROMs. It maps the VGA scan position onto sprite-local row and column, selects the animation frame and steps it on vertical-blank ticks. It aligns the ROM's one-cycle registered read with its own pipeline and emits an overlay pixel with black treated as transparent. It sits between the VGA sync generator and the final RGB mux.

## Interface
Parameters:
- NUM_FRAMES, 10, animation frames (ROM select 0..NUM_FRAMES-1)
- FRAME_TICKS, 4, frame_tick pulses per animation frame
- TRANSPARENT, 12'h000, ROM colour treated as see-through

Ports:
- clk  in  1  system clock (pixel clock domain)
- reset_n  in  1  synchronous, active-low reset
- pixel_x  in  10  current scan column
- pixel_y  in  10  current scan row
- video_on  in  1  active display area
- frame_tick  in  1  one-cycle pulse from the sync generator at start of vertical blank
- trigger  in  1  start animation; level sampled every cycle
- pos_x, pos_y  in  10 each  sprite top-left, latched on accepted trigger
- rom_row, rom_col  out  6 each  sprite-local address to the ROM bank
- rom_frame  out  4  ROM bank select
- rom_data  in  12  colour from the selected ROM, valid one cycle after rom_row/rom_col
- rgb_out  out  12  overlay colour
- sprite_on  out  1  rgb_out is opaque sprite pixel
- busy  out  1  animation in progress
- done  out  1  one-cycle pulse after the last frame

## Operation
- FSM states: IDLE, PLAY, DONE.
- IDLE: trigger=1 -> latch pos_x/pos_y, frame=0, tick_cnt=0, go to PLAY.
- PLAY: on frame_tick, tick_cnt++. When frame_tick and tick_cnt==FRAME_TICKS-1: tick_cnt=0. If frame==NUM_FRAMES-1 go to DONE; otherwise frame++.
- PLAY with trigger=1 (retrigger): relatch position, frame=0, tick_cnt=0, stay in PLAY. Retrigger has priority over a coincident frame_tick.
- DONE: done=1 for exactly one cycle, then IDLE. Trigger in DONE is ignored.
- busy=1 in PLAY only. rom_frame=frame register.
- Hit test, stage 0, combinational: dx=pixel_x-pos_x and dy=pixel_y-pos_y, both 11-bit unsigned. hit = (pixel_x>=pos_x) & (dx<64) & (pixel_y>=pos_y) & (dy<64) & video_on & busy.
- Box extending past screen edge is clipped naturally. No wrap-around: pos_x=1000 never hits at pixel_x<1000.
- Stage 1, registered: rom_row=dy[5:0], rom_col=dx[5:0], hit_s1=hit. When hit=0, rom_row/rom_col=0.
- Stage 2, ROM internal register: hit_s2<=hit_s1.
- Stage 3, registered: sprite_on = hit_s2 & (rom_data!=TRANSPARENT). rgb_out = sprite_on ? rom_data : 12'h000.

## Timing
- Reset (reset_n=0 at clk edge): state=IDLE, frame=0, tick_cnt=0, pos=0. rom_row=rom_col=rom_frame=0, rgb_out=0, sprite_on=0, busy=0, done=0, all pipeline valids=0.
- Reset mid-PLAY aborts the animation with no done pulse.
- Latency: pixel_x/pixel_y at cycle N -> rom_row/rom_col at N+1 -> rgb_out/sprite_on at N+3. The sync generator delays hsync/vsync by 3 cycles to match.
- Trigger accepted at edge N: busy=1 from N+1. Pixels presented at N+1 onward can hit.
- rom_frame changes only on the cycle after frame_tick, which falls inside vertical blank, so no frame tear.
- Full animation: NUM_FRAMES*FRAME_TICKS frame_ticks from trigger to DONE. done is asserted the cycle after the final tick; busy falls on the same cycle.

## Configuration
- BLOOD_MIRROR_EN defined: adds input mirror (1 bit), latched with pos on accepted trigger. When the latched mirror=1, rom_col = 63-dx[5:0]; rom_row is unchanged.
- BLOOD_MIRROR_EN undefined: no mirror port; rom_col=dx[5:0].

## Test plan
- Reset: hold reset_n=0 with trigger=1 -> all outputs 0, busy=0. Release -> next cycle accepts trigger.
- Trigger pos=(100,200), scan pixel (100,200) at cycle N -> rom_row=0, rom_col=0 at N+1. ROM model returns 12'hE00 -> rgb_out=12'hE00, sprite_on=1 at N+3. Pixel (164,200) -> sprite_on=0. Pixel (163,263) -> rom_row=63, rom_col=63.
- Transparent: ROM returns 12'h000 inside box -> sprite_on=0, rgb_out=0. video_on=0 inside box -> sprite_on=0.
- Frame stepping: defaults -> rom_frame=1 after 4 ticks, 9 after 36. Tick 40 -> done pulses one cycle, busy=0, state IDLE.
- Retrigger after 17 ticks with pos=(10,10) -> rom_frame=0, new box active. Coincident frame_tick is ignored; done after 40 further ticks.
- BLOOD_MIRROR_EN with mirror=1: pixel (100,200) at pos (100,200) -> rom_col=63. Pixel (163,200) -> rom_col=0.
